vec_loader: RTL and testbench

- Upstream operand packer for the calculation core.
- Accepts a narrow word stream over a valid/ready handshake and assembles one 512-bit A vector followed by one 512-bit B vector.
- Presents each completed A/B pair to the core on held output registers, with a valid/ready handshake.
- Staging plus output registers form a two-deep pair buffer, so streaming continues while the core consumes.

---
 rtl/vec_loader_pkg.sv | 15 +
 rtl/vec_shift_reg.sv | 33 +++
 rtl/vec_loader.sv | 118 +++++++++++
 tb/tb_vec_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vec_loader_pkg.sv
// rtl/vec_loader_pkg.sv - shared types and widths for the vec_loader operand packer.
package vec_loader_pkg;

  localparam int VEC_W  = 512;
  localparam int DATA_W = 32;
  localparam int BEATS  = VEC_W / DATA_W;
  localparam int RES_W  = 24;

  typedef enum logic [1:0] {
    FILL_A,
    FILL_B,
    FULL
  } state_t;

endpackage

// File: rtl/vec_shift_reg.sv
// rtl/vec_shift_reg.sv - BEATS-slot staging register with word-indexed writes.
// q_next exposes the contents with this cycle's write already merged in.
module vec_shift_reg #(
  parameter int DATA_W = vec_loader_pkg::DATA_W,
  parameter int BEATS  = vec_loader_pkg::BEATS,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        idx,
  input  logic [DATA_W-1:0]       wdata,
  output logic [BEATS*DATA_W-1:0] q_next
);

  logic [BEATS*DATA_W-1:0] q;

  always_comb begin
    q_next = q;
    if (we) begin
      q_next[idx*DATA_W +: DATA_W] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/vec_loader.sv
// rtl/vec_loader.sv - packs a word stream into A/B vector pairs for the core.
// Define VEC_LOADER_BSWAP_EN to byte-reverse each word for big-endian sources.
module vec_loader #(
  parameter int DATA_W = vec_loader_pkg::DATA_W,
  parameter int VEC_W  = vec_loader_pkg::VEC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  A,
  output logic [VEC_W-1:0]  B,
  output logic              err_last
);

  import vec_loader_pkg::*;

  localparam int BEATS = VEC_W / DATA_W;
  localparam int CNT_W = $clog2(2 * BEATS);
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * BEATS - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              xfer, last_beat, out_free, move, we_a, we_b;
  logic [IDX_W-1:0]  slot;
  logic [DATA_W-1:0] word;
  logic [VEC_W-1:0]  stg_a_nxt, stg_b_nxt;

  assign in_ready  = (state != FULL);
  assign xfer      = in_valid & in_ready;
  assign last_beat = (cnt == LAST_CNT);
  assign out_free  = !out_valid | out_ready;
  // A final-beat transfer with a free output bypasses FULL entirely.
  assign move      = out_free & ((state == FULL) | (xfer & last_beat));
  assign we_a      = xfer & (state == FILL_A);
  assign we_b      = xfer & (state == FILL_B);
  assign slot      = IDX_W'((cnt >= CNT_W'(BEATS)) ? cnt - CNT_W'(BEATS) : cnt);

`ifdef VEC_LOADER_BSWAP_EN
  always_comb begin
    word = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      word[i*8 +: 8] = in_data[DATA_W-8-i*8 +: 8];
    end
  end
`else
  assign word = in_data;
`endif

  vec_shift_reg #(
    .DATA_W(DATA_W),
    .BEATS (BEATS),
    .IDX_W (IDX_W)
  ) u_stg_a (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_a),
    .idx   (slot),
    .wdata (word),
    .q_next(stg_a_nxt)
  );

  vec_shift_reg #(
    .DATA_W(DATA_W),
    .BEATS (BEATS),
    .IDX_W (IDX_W)
  ) u_stg_b (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_b),
    .idx   (slot),
    .wdata (word),
    .q_next(stg_b_nxt)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL_A: if (xfer && cnt == MID_CNT) state_nxt = FILL_B;
      FILL_B: if (xfer && last_beat) state_nxt = out_free ? FILL_A : FULL;
      FULL:   if (out_free) state_nxt = FILL_A;
      default: state_nxt = FILL_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL_A;
      cnt       <= '0;
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      err_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
      end
      if (move) begin
        A         <= stg_a_nxt;
        B         <= stg_b_nxt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && (in_last != last_beat)) begin
        err_last <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vec_loader.sv
// tb/tb_vec_loader.sv - directed self-checking bench for vec_loader.
module tb_vec_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] A;
  logic [511:0] B;
  logic         err_last;

  int n_assert = 0;
  int n_fail   = 0;

  vec_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .A        (A),
    .B        (B),
    .err_last (err_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] src(input logic [31:0] w);
`ifdef VEC_LOADER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [511:0] mk_vec(input logic [31:0] base);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = src(base + 32'(i));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic apply_reset;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", 512'(out_valid), 512'(0));
    chk("rst_async_A", A, 512'(0));
    chk("rst_async_B", B, 512'(0));
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int drops, hits, pos1, pos2;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("reset_out_valid", 512'(out_valid), 512'(0));
    chk("reset_A", A, 512'(0));
    chk("reset_B", B, 512'(0));
    chk("reset_err_last", 512'(err_last), 512'(0));
    chk("reset_in_ready", 512'(in_ready), 512'(1));
    rst_n = 1'b1;
    tick();

    // single pair, output always free
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) chk("single_pre_valid", 512'(out_valid), 512'(0));
      beat(32'(i), i == 31);
    end
    chk("single_out_valid", 512'(out_valid), 512'(1));
    chk("single_A_lsw", 512'(A[31:0]), 512'(src(32'h0)));
    chk("single_A_msw", 512'(A[511:480]), 512'(src(32'hF)));
    chk("single_B_lsw", 512'(B[31:0]), 512'(src(32'h10)));
    chk("single_A", A, mk_vec(32'h0));
    chk("single_B", B, mk_vec(32'h10));
    tick();
    chk("single_drain", 512'(out_valid), 512'(0));

    // back-to-back pairs
    drops = 0; hits = 0; pos1 = 0; pos2 = 0;
    for (int i = 0; i < 64; i++) begin
      if (!in_ready) drops++;
      beat(32'h100 + 32'(i), (i % 32) == 31);
      if (out_valid) begin
        hits++;
        if (hits == 1) begin
          pos1 = i;
          chk("b2b_A1", A, mk_vec(32'h100));
          chk("b2b_B1", B, mk_vec(32'h110));
        end else begin
          pos2 = i;
          chk("b2b_A2", A, mk_vec(32'h120));
          chk("b2b_B2", B, mk_vec(32'h130));
        end
      end
    end
    chk("b2b_in_ready_drops", 512'(drops), 512'(0));
    chk("b2b_valid_count", 512'(hits), 512'(2));
    chk("b2b_spacing", 512'(pos2 - pos1), 512'(32));
    tick();

    // backpressure: two pairs with the core stalled
    out_ready = 1'b0;
    drops = 0;
    for (int i = 0; i < 64; i++) begin
      if (!in_ready) drops++;
      beat(32'h200 + 32'(i), (i % 32) == 31);
      if (i == 31) chk("bp_first_valid", 512'(out_valid), 512'(1));
    end
    chk("bp_in_ready_drops", 512'(drops), 512'(0));
    chk("bp_full_in_ready", 512'(in_ready), 512'(0));
    chk("bp_held_valid", 512'(out_valid), 512'(1));
    chk("bp_held_A", A, mk_vec(32'h200));
    chk("bp_held_B", B, mk_vec(32'h210));
    tick();
    chk("bp_still_A", A, mk_vec(32'h200));
    chk("bp_still_in_ready", 512'(in_ready), 512'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_second_valid", 512'(out_valid), 512'(1));
    chk("bp_second_A", A, mk_vec(32'h220));
    chk("bp_second_B", B, mk_vec(32'h230));
    chk("bp_in_ready_back", 512'(in_ready), 512'(1));
    out_ready = 1'b1;
    tick();
    chk("bp_drain", 512'(out_valid), 512'(0));

    // reset with a pair pending and 20 words staged
    out_ready = 1'b0;
    for (int i = 0; i < 52; i++) beat(32'h300 + 32'(i), i == 31);
    chk("midfill_pending", 512'(out_valid), 512'(1));
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) beat(32'h400 + 32'(i), i == 31);
    chk("midfill_clean_valid", 512'(out_valid), 512'(1));
    chk("midfill_clean_A", A, mk_vec(32'h400));
    chk("midfill_clean_B", B, mk_vec(32'h410));
    chk("midfill_err_clear", 512'(err_last), 512'(0));
    tick();

    // early in_last on word 5
    for (int i = 0; i < 32; i++) begin
      beat(32'h500 + 32'(i), (i == 5) || (i == 31));
      if (i == 4) chk("err_before", 512'(err_last), 512'(0));
      if (i == 5) chk("err_set", 512'(err_last), 512'(1));
    end
    chk("err_pair_valid", 512'(out_valid), 512'(1));
    chk("err_pair_A", A, mk_vec(32'h500));
    chk("err_pair_B", B, mk_vec(32'h510));
    tick();
    chk("err_sticky", 512'(err_last), 512'(1));

    // missing in_last on the final beat
    apply_reset();
    chk("err_cleared_by_reset", 512'(err_last), 512'(0));
    for (int i = 0; i < 32; i++) begin
      beat(32'h600 + 32'(i), 1'b0);
      if (i == 30) chk("noLast_before", 512'(err_last), 512'(0));
    end
    chk("noLast_err", 512'(err_last), 512'(1));
    chk("noLast_valid", 512'(out_valid), 512'(1));
    chk("noLast_B", B, mk_vec(32'h610));
    tick();

    // byte order of a word at beat 0
    beat(32'h11223344, 1'b0);
    for (int i = 1; i < 32; i++) beat(32'h700 + 32'(i), i == 31);
`ifdef VEC_LOADER_BSWAP_EN
    chk("bswap_A_lsw", 512'(A[31:0]), 512'(32'h44332211));
`else
    chk("bswap_A_lsw", 512'(A[31:0]), 512'(32'h11223344));
`endif
    chk("bswap_B_lsw", 512'(B[31:0]), 512'(src(32'h710)));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
